// File: rtl/mem_access_unit_if.sv
// Data-memory port between the MEM-stage access unit (master) and the memory (slave).
// Handshake: the master raises dmReq and holds dmWe/dmAddr/dmBe/dmWdata stable until
// it samples dmAck high on a rising edge; dmRdata is valid only in that dmAck cycle.
interface mem_access_unit_if;
    logic        dmReq;
    logic        dmWe;
    logic [31:0] dmAddr;
    logic [3:0]  dmBe;
    logic [31:0] dmWdata;
    logic [31:0] dmRdata;
    logic        dmAck;

    modport master (output dmReq, dmWe, dmAddr, dmBe, dmWdata,
                    input  dmRdata, dmAck);
    modport slave  (input  dmReq, dmWe, dmAddr, dmBe, dmWdata,
                    output dmRdata, dmAck);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one bus transaction per access, stalls until ack or timeout,
// byte-lane steering for stores and lane select plus extension for loads.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               aluOutM,
    input  logic [31:0]               writeDataM,
    input  logic                      memReadM,
    input  logic                      memWriteM,
    input  logic [1:0]                memSizeM,
    input  logic                      memUnsignedM,
    input  logic                      flushM,
    output logic                      stallM,
    output logic [31:0]               readDataM,
    output logic                      excAddrErrM,
    output logic                      busErrM,
    output logic [1:0]                o_dbg_state,
    mem_access_unit_if.master         dm
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_t;

    state_t      r_state, w_next;
    logic        r_we, r_uns, r_err;
    logic [1:0]  r_size, r_off;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_be;
    logic [7:0]  r_cnt;

    logic        w_access, w_mis, w_start, w_tmo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load, w_shift_b, w_shift_h;

    assign w_access = (memReadM | memWriteM) & ~flushM;

    always_comb begin
        w_mis = 1'b0;
        case (memSizeM)
            2'b00:   w_mis = 1'b0;
            2'b01:   w_mis = aluOutM[0];
            default: w_mis = (aluOutM[1:0] != 2'b00);
        endcase
    end

    assign w_start = (r_state == S_IDLE) & w_access & ~w_mis;
    assign w_tmo   = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

    // Stores replicate data across lanes; loads read the whole word and select later.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = 32'h0;
        if (memWriteM) begin
            case (memSizeM)
                2'b00: begin
                    w_be    = 4'b0001 << aluOutM[1:0];
                    w_wdata = {4{writeDataM[7:0]}};
                end
                2'b01: begin
                    w_be    = aluOutM[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{writeDataM[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = writeDataM;
                end
            endcase
        end
    end

    assign w_shift_b = dm.dmRdata >> {r_off, 3'b000};
    assign w_shift_h = dm.dmRdata >> {r_off[1], 4'b0000};

    always_comb begin
        w_load = dm.dmRdata;
        case (r_size)
            2'b00:   w_load = r_uns ? {24'h0, w_shift_b[7:0]}
                                    : {{24{w_shift_b[7]}}, w_shift_b[7:0]};
            2'b01:   w_load = r_uns ? {16'h0, w_shift_h[15:0]}
                                    : {{16{w_shift_h[15]}}, w_shift_h[15:0]};
            default: w_load = dm.dmRdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_REQ;
            S_REQ:   if (dm.dmAck || w_tmo) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
            r_size  <= 2'b00;
            r_off   <= 2'b00;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_be    <= 4'h0;
            r_cnt   <= 8'h0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_addr  <= {aluOutM[31:2], 2'b00};
                    r_we    <= memWriteM;
                    r_be    <= w_be;
                    r_wdata <= w_wdata;
                    r_size  <= memSizeM;
                    r_uns   <= memUnsignedM;
                    r_off   <= aluOutM[1:0];
                    r_cnt   <= 8'h0;
                    r_err   <= 1'b0;
                end
                // Ack takes precedence over a timeout landing in the same cycle.
                S_REQ: if (dm.dmAck) begin
                    if (!r_we) r_rdata <= w_load;
                end else if (w_tmo) begin
                    r_rdata <= 32'h0;
                    r_err   <= 1'b1;
                end else begin
                    r_cnt   <= r_cnt + 8'h1;
                end
                default: ;
            endcase
        end
    end

    assign dm.dmReq     = (r_state == S_REQ);
    assign dm.dmWe      = r_we;
    assign dm.dmAddr    = r_addr;
    assign dm.dmBe      = r_be;
    assign dm.dmWdata   = r_wdata;
    assign stallM       = w_start | (r_state == S_REQ);
    assign excAddrErrM  = (r_state == S_IDLE) & w_access & w_mis;
    assign busErrM      = (r_state == S_DONE) & r_err;
    assign readDataM    = r_rdata;
    assign o_dbg_state  = r_state;
endmodule
